// File: rtl/id_funct_seq.sv
// id_funct_seq: registered ID-stage ALU FUNCT generator with MULT/DIV occupancy sequencing.
// Maps opcode (+ SPECIAL funct field) to the ALU FUNCT code, holds it in an ID/EX
// register behind a valid/ready handshake, and stalls issue while a multi-cycle
// multiply/divide is modelled as busy.
// Optional feature macro: FUNCTGEN_ILLEGAL_OP_EN (adds the illegal_op output).
module id_funct_seq #(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               md_busy,
  output logic               md_done
`ifdef FUNCTGEN_ILLEGAL_OP_EN
  ,
  output logic               illegal_op
`endif
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [FUNCT_W-1:0] F_NOP   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_XOR   = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLTU  = FUNCT_W'(6'b101011);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'b011010);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);

  typedef enum logic {
    S_IDLE,
    S_MD_BUSY
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [FUNCT_W-1:0] w_map;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic [FUNCT_W-1:0] r_funct;
  logic               r_out_valid;

  // Opcode / SPECIAL funct to ALU FUNCT mapping
  always_comb begin
    w_map = F_NOP;
    case (op)
      OP_W'(6'b000000): w_map = funct_in;
      OP_W'(6'b001111),
      OP_W'(6'b000011),
      OP_W'(6'b001101): w_map = F_OR;
      OP_W'(6'b100000),
      OP_W'(6'b100100),
      OP_W'(6'b100001),
      OP_W'(6'b100011),
      OP_W'(6'b101000),
      OP_W'(6'b101011),
      OP_W'(6'b001001): w_map = F_ADDU;
      OP_W'(6'b001100): w_map = F_AND;
      OP_W'(6'b001110): w_map = F_XOR;
      OP_W'(6'b001010): w_map = F_SLT;
      OP_W'(6'b001011): w_map = F_SLTU;
      default:          w_map = F_NOP;
    endcase
  end

  assign w_is_mul  = (w_map == F_MULT) || (w_map == F_MULTU);
  assign w_is_div  = (w_map == F_DIV)  || (w_map == F_DIVU);
  assign in_ready  = (r_state == S_IDLE) && !flush && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign md_busy   = (r_state == S_MD_BUSY);
  assign funct     = r_funct;
  assign out_valid = r_out_valid;

  // FSM state and busy counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state, counter update and md_done pulse (an aborting flush suppresses md_done)
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    md_done     = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            w_state_nxt = S_MD_BUSY;
            w_cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
          end else if (w_accept && w_is_div) begin
            w_state_nxt = S_MD_BUSY;
            w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        S_MD_BUSY: begin
          if (r_cnt == '0) begin
            md_done     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ID/EX output register with valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct     <= F_NOP;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_funct     <= w_map;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef FUNCTGEN_ILLEGAL_OP_EN
  logic w_illegal;

  // Flag opcodes falling to the NOP default and unsupported SPECIAL functs
  always_comb begin
    w_illegal = 1'b0;
    case (op)
      OP_W'(6'b000000): begin
        case (funct_in)
          FUNCT_W'(6'b100001), FUNCT_W'(6'b100011), FUNCT_W'(6'b100100),
          FUNCT_W'(6'b100101), FUNCT_W'(6'b100110), FUNCT_W'(6'b100111),
          FUNCT_W'(6'b101010), FUNCT_W'(6'b101011), FUNCT_W'(6'b000000),
          FUNCT_W'(6'b000010), FUNCT_W'(6'b000011), FUNCT_W'(6'b000100),
          FUNCT_W'(6'b000110), FUNCT_W'(6'b000111), FUNCT_W'(6'b001000),
          FUNCT_W'(6'b001001), FUNCT_W'(6'b011000), FUNCT_W'(6'b011001),
          FUNCT_W'(6'b011010), FUNCT_W'(6'b011011), FUNCT_W'(6'b010000),
          FUNCT_W'(6'b010010), FUNCT_W'(6'b010001), FUNCT_W'(6'b010011):
            w_illegal = 1'b0;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_W'(6'b001111), OP_W'(6'b000011), OP_W'(6'b001101),
      OP_W'(6'b100000), OP_W'(6'b100100), OP_W'(6'b100001),
      OP_W'(6'b100011), OP_W'(6'b101000), OP_W'(6'b101011),
      OP_W'(6'b001001), OP_W'(6'b001100), OP_W'(6'b001110),
      OP_W'(6'b001010), OP_W'(6'b001011): w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal flag registered alongside funct on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (!flush && w_accept) begin
      illegal_op <= w_illegal;
    end
  end
`endif

endmodule
